mod_n_counter_arbiter: RTL and testbench

Shares one external mod-N counter between NREQ requesters. Round-robin arbitration over command requests: load, increment, decrement, clear. Translates each granted command into a single-cycle control strobe on the counter's ce/reset/we/up/down inputs. Returns the post-operation value with a one-cycle ack. Enforces true modular wrap (0 <-> M-1) and rejects out-of-range loads.

---
 rtl/mod_n_counter_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mod_n_counter_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mod_n_counter_arbiter
// Purpose  : Shares one external mod-M counter between NREQ requesters.
//            A round-robin arbiter grants one command (load / inc / dec /
//            clear). The command becomes a single-cycle strobe on the counter's
//            control inputs. The post-operation counter value is returned with a
//            one-cycle acknowledge. Modular wrap (0 <-> M-1) is enforced here,
//            and loads of out-of-range values are rejected.
// Config   : ARB_FIXED_PRIO_EN - when defined, the arbiter uses fixed priority
//            (lowest index wins) and has no round-robin pointer.
// Ports    : i_clk, i_reset        clock, synchronous active-high reset
//            i_req  [NREQ]         per-requester request, held until o_ack
//            i_op   [2*NREQ]       op per lane: 00 load, 01 inc, 10 dec, 11 clr
//            i_data [N*NREQ]       load value per lane
//            o_ack  [NREQ]         one-hot completion pulse
//            o_err                 command rejected (valid with o_ack)
//            o_rdata[N]            counter value after the command
//            o_cnt_*               control strobes to the external counter
//            i_cnt_data[N]         current external counter value
// Revision : 1.0 - initial release
// ============================================================================
module mod_n_counter_arbiter #(
   parameter  int NREQ = 4,
   parameter  int M    = 4000,
   localparam int N    = $clog2(M)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NREQ-1:0]   i_req,
   input  logic [2*NREQ-1:0] i_op,
   input  logic [N*NREQ-1:0] i_data,
   output logic [NREQ-1:0]   o_ack,
   output logic              o_err,
   output logic [N-1:0]      o_rdata,
   output logic              o_cnt_ce,
   output logic              o_cnt_reset,
   output logic              o_cnt_we,
   output logic [N-1:0]      o_cnt_data,
   output logic              o_cnt_up,
   output logic              o_cnt_down,
   input  logic [N-1:0]      i_cnt_data
);

   localparam int           IDX_W   = $clog2(NREQ);
   localparam logic [N-1:0] MAX_VAL = N'(M - 1);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    gnt_q;
   logic                rej_q;
   logic [NREQ-1:0]     ack_q;
   logic                err_q;
   logic [N-1:0]        rdata_q;
   logic                cnt_ce_q;
   logic                cnt_reset_q;
   logic                cnt_we_q;
   logic [N-1:0]        cnt_data_q;
   logic                cnt_up_q;
   logic                cnt_down_q;

   // Arbitration result for the current cycle (only used in IDLE)
   logic                w_any;
   logic [IDX_W-1:0]    w_gnt;
   logic [IDX_W-1:0]    w_lane;
   logic [1:0]          w_op;
   logic [N-1:0]        w_data;
   logic [NREQ-1:0]     w_gnt_oh;

   // Next values of the strobe registers, decoded at grant time
   logic                cnt_ce_d;
   logic                cnt_reset_d;
   logic                cnt_we_d;
   logic [N-1:0]        cnt_data_d;
   logic                cnt_up_d;
   logic                cnt_down_d;
   logic                rej_d;

`ifndef ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]    ptr_q;
`endif

   // ------------------------------------------------------------------------
   // Requester selection
   // ------------------------------------------------------------------------
   always_comb begin
      w_any  = 1'b0;
      w_gnt  = '0;
      w_lane = '0;
`ifdef ARB_FIXED_PRIO_EN
      // Walk downwards so the lowest set index is the last one written.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_any = 1'b1;
            w_gnt = IDX_W'(i);
         end
      end
`else
      // Search starts one past the last winner; the last winner is checked last.
      for (int i = 1; i <= NREQ; i++) begin
         w_lane = IDX_W'((int'(ptr_q) + i) % NREQ);
         if (!w_any && i_req[w_lane]) begin
            w_any = 1'b1;
            w_gnt = w_lane;
         end
      end
`endif
   end

   // Lane mux for the selected requester's op and load value
   always_comb begin
      w_op   = '0;
      w_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt == IDX_W'(k)) begin
            w_op   = i_op[2*k +: 2];
            w_data = i_data[N*k +: N];
         end
      end
   end

   // One-hot acknowledge vector of the latched grant
   always_comb begin
      w_gnt_oh = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_q == IDX_W'(k)) begin
            w_gnt_oh[k] = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Command decode. The counter value sampled in the grant cycle decides
   // the wrap cases, so the strobes can be registered and are glitch-free
   // during ISSUE.
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_ce_d    = 1'b0;
      cnt_reset_d = 1'b0;
      cnt_we_d    = 1'b0;
      cnt_data_d  = '0;
      cnt_up_d    = 1'b0;
      cnt_down_d  = 1'b0;
      rej_d       = 1'b0;
      case (w_op)
         OP_LOAD: begin
            if (w_data <= MAX_VAL) begin
               cnt_ce_d   = 1'b1;
               cnt_we_d   = 1'b1;
               cnt_data_d = w_data;
            end else begin
               rej_d = 1'b1;
            end
         end
         OP_INC: begin
            cnt_ce_d = 1'b1;
            if (i_cnt_data == MAX_VAL) begin
               cnt_reset_d = 1'b1;
            end else begin
               cnt_up_d = 1'b1;
            end
         end
         OP_DEC: begin
            cnt_ce_d = 1'b1;
            if (i_cnt_data == '0) begin
               cnt_we_d   = 1'b1;
               cnt_data_d = MAX_VAL;
            end else begin
               cnt_down_d = 1'b1;
            end
         end
         default: begin
            cnt_ce_d    = 1'b1;
            cnt_reset_d = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Command FSM: IDLE -> ISSUE -> CAPTURE -> IDLE
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         rej_q       <= 1'b0;
         ack_q       <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         cnt_ce_q    <= 1'b0;
         cnt_reset_q <= 1'b0;
         cnt_we_q    <= 1'b0;
         cnt_data_q  <= '0;
         cnt_up_q    <= 1'b0;
         cnt_down_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q       <= IDX_W'(NREQ - 1);
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               ack_q <= '0;
               err_q <= 1'b0;
               if (w_any) begin
                  gnt_q       <= w_gnt;
                  rej_q       <= rej_d;
                  cnt_ce_q    <= cnt_ce_d;
                  cnt_reset_q <= cnt_reset_d;
                  cnt_we_q    <= cnt_we_d;
                  cnt_data_q  <= cnt_data_d;
                  cnt_up_q    <= cnt_up_d;
                  cnt_down_q  <= cnt_down_d;
`ifndef ARB_FIXED_PRIO_EN
                  ptr_q       <= w_gnt;
`endif
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_ce_q    <= 1'b0;
               cnt_reset_q <= 1'b0;
               cnt_we_q    <= 1'b0;
               cnt_data_q  <= '0;
               cnt_up_q    <= 1'b0;
               cnt_down_q  <= 1'b0;
               ack_q       <= w_gnt_oh;
               err_q       <= rej_q;
               state_q     <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               ack_q   <= '0;
               err_q   <= 1'b0;
               rdata_q <= i_cnt_data;
               state_q <= ST_IDLE;
            end
            default: begin
               ack_q       <= '0;
               err_q       <= 1'b0;
               cnt_ce_q    <= 1'b0;
               cnt_reset_q <= 1'b0;
               cnt_we_q    <= 1'b0;
               cnt_data_q  <= '0;
               cnt_up_q    <= 1'b0;
               cnt_down_q  <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   // The counter has already absorbed the strobe when CAPTURE begins, so its
   // live output is the post-operation value; outside CAPTURE the last
   // captured value is held.
   assign o_rdata     = (state_q == ST_CAPTURE) ? i_cnt_data : rdata_q;
   assign o_ack       = ack_q;
   assign o_err       = err_q;
   assign o_cnt_ce    = cnt_ce_q;
   assign o_cnt_reset = cnt_reset_q;
   assign o_cnt_we    = cnt_we_q;
   assign o_cnt_data  = cnt_data_q;
   assign o_cnt_up    = cnt_up_q;
   assign o_cnt_down  = cnt_down_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_n_counter_arbiter
// Purpose  : Self-checking bench for mod_n_counter_arbiter. It contains an
//            external counter model driven by the DUT strobes. A reference
//            model predicts the arbitration winner, the strobes, and the
//            command result from the command rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_n_counter_arbiter;

   localparam int NREQ = 4;
   localparam int M    = 4000;
   localparam int N    = $clog2(M);

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_v;
   logic [1:0]        op_a   [NREQ];
   logic [N-1:0]      data_a [NREQ];
   logic [2*NREQ-1:0] op_bus;
   logic [N*NREQ-1:0] data_bus;
   logic [NREQ-1:0]   ack;
   logic              err;
   logic [N-1:0]      rdata;
   logic              cnt_ce, cnt_reset, cnt_we, cnt_up, cnt_down;
   logic [N-1:0]      cnt_data;
   logic [N-1:0]      cnt_q;
   logic              pre_en;
   logic [N-1:0]      pre_val;

   int n_checks = 0;
   int n_fail   = 0;
   int ref_cnt  = 0;
   int last_w   = NREQ - 1;

   mod_n_counter_arbiter #(.NREQ(NREQ), .M(M)) u_dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_req       (req_v),
      .i_op        (op_bus),
      .i_data      (data_bus),
      .o_ack       (ack),
      .o_err       (err),
      .o_rdata     (rdata),
      .o_cnt_ce    (cnt_ce),
      .o_cnt_reset (cnt_reset),
      .o_cnt_we    (cnt_we),
      .o_cnt_data  (cnt_data),
      .o_cnt_up    (cnt_up),
      .o_cnt_down  (cnt_down),
      .i_cnt_data  (cnt_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         op_bus[2*k +: 2]   = op_a[k];
         data_bus[N*k +: N] = data_a[k];
      end
   end

   // External counter: plain up/down/load register, no wrap logic of its own
   always @(posedge clk) begin
      if (pre_en)              cnt_q <= pre_val;
      else if (cnt_ce) begin
         if (cnt_reset)        cnt_q <= '0;
         else if (cnt_we)      cnt_q <= cnt_data;
         else if (cnt_up)      cnt_q <= cnt_q + 1'b1;
         else if (cnt_down)    cnt_q <= cnt_q - 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Winner according to the arbitration rule
   function automatic int pick(input logic [NREQ-1:0] r);
      int w;
      w = -1;
`ifdef ARB_FIXED_PRIO_EN
      for (int j = NREQ - 1; j >= 0; j--) if (r[j]) w = j;
`else
      for (int s = NREQ; s >= 1; s--) begin
         for (int j = 0; j < NREQ; j++) begin
            if (j == (last_w + s) % NREQ && r[j]) w = j;
         end
      end
`endif
      return w;
   endfunction

   task automatic rand_lane(input int k);
      op_a[k]   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
         data_a[k] = N'($urandom_range(M, (1 << N) - 1));
      else
         data_a[k] = N'($urandom_range(0, M - 1));
   endtask

   // Force the external counter to v during one request-free idle cycle
   task automatic preset(input int v);
      pre_en  = 1'b1;
      pre_val = N'(v);
      @(negedge clk);
      pre_en  = 1'b0;
      check("idle_ack", 32'(ack), 0);
      check("idle_ce", 32'(cnt_ce), 0);
      ref_cnt = v;
   endtask

   // One full command. It starts and ends at an IDLE-state negedge.
   task automatic step(input bit keep, input bit renew);
      int w, d, res;
      bit e_err;
      int e_ce, e_rst, e_we, e_up, e_dn, e_cd;
      logic [1:0] op;
      if (req_v == '0) req_v[0] = 1'b1;
      w  = pick(req_v);
      op = op_a[w];
      d  = int'(data_a[w]);
      e_ce = 0; e_rst = 0; e_we = 0; e_up = 0; e_dn = 0; e_cd = 0; e_err = 1'b0;
      res = ref_cnt;
      case (op)
         2'b00: if (d < M) begin res = d; e_ce = 1; e_we = 1; e_cd = d; end
                else e_err = 1'b1;
         2'b01: begin
            res  = (ref_cnt + 1) % M;
            e_ce = 1;
            if (ref_cnt == M - 1) e_rst = 1; else e_up = 1;
         end
         2'b10: begin
            res  = (ref_cnt + M - 1) % M;
            e_ce = 1;
            if (ref_cnt == 0) begin e_we = 1; e_cd = M - 1; end else e_dn = 1;
         end
         default: begin res = 0; e_ce = 1; e_rst = 1; end
      endcase
      @(negedge clk);   // ISSUE
      check("issue_ack", 32'(ack), 0);
      check("issue_ce", 32'(cnt_ce), 32'(e_ce));
      check("issue_reset", 32'(cnt_reset), 32'(e_rst));
      check("issue_we", 32'(cnt_we), 32'(e_we));
      check("issue_up", 32'(cnt_up), 32'(e_up));
      check("issue_down", 32'(cnt_down), 32'(e_dn));
      if (e_we != 0) check("issue_cnt_data", 32'(cnt_data), 32'(e_cd));
      @(negedge clk);   // CAPTURE
      check("cap_ack", 32'(ack), 32'(1) << w);
      check("cap_err", 32'(err), 32'(e_err));
      check("cap_rdata", 32'(rdata), 32'(res));
      check("cap_ce", 32'(cnt_ce), 0);
      ref_cnt = res;
      last_w  = w;
      if (!keep) req_v[w] = 1'b0;
      else if (renew) rand_lane(w);
      @(negedge clk);   // IDLE
      check("idle_ack", 32'(ack), 0);
      check("hold_rdata", 32'(rdata), 32'(ref_cnt));
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] saved;
      rst = 1'b1; req_v = '0; pre_en = 1'b0; pre_val = '0;
      for (int k = 0; k < NREQ; k++) begin op_a[k] = 2'b00; data_a[k] = '0; end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ack", 32'(ack), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_ce", 32'(cnt_ce), 0);
      check("rst_strobes", {28'd0, cnt_reset, cnt_we, cnt_up, cnt_down}, 0);
      check("rst_cnt_data", 32'(cnt_data), 0);
      preset(500);

      // Directed: load, inc wrap, dec wrap, rejected load
      req_v = 4'b0001; op_a[0] = 2'b00; data_a[0] = N'(1234); step(1'b0, 1'b0);
      preset(M - 1);
      req_v = 4'b0010; op_a[1] = 2'b01; step(1'b0, 1'b0);
      preset(0);
      req_v = 4'b0100; op_a[2] = 2'b10; step(1'b0, 1'b0);
      req_v = 4'b1000; op_a[3] = 2'b00; data_a[3] = N'(M); step(1'b0, 1'b0);

      // All four requesters hold inc from 10
      preset(10);
      for (int k = 0; k < NREQ; k++) op_a[k] = 2'b01;
      req_v = '1;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      req_v = '0;
      @(negedge clk);

      // Reset during ISSUE of load 77
      req_v = 4'b0001; op_a[0] = 2'b00; data_a[0] = N'(77);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstiss_ack", 32'(ack), 0);
      check("rstiss_ce", 32'(cnt_ce), 0);
      check("rstiss_strobes", {28'd0, cnt_reset, cnt_we, cnt_up, cnt_down}, 0);
      ref_cnt = int'(cnt_q);
      last_w  = NREQ - 1;
      req_v = 4'b0101; op_a[2] = 2'b01;
      step(1'b0, 1'b0);
      req_v = '0;

      // Randomized traffic
      for (int it = 0; it < 120; it++) begin
         if ($urandom_range(0, 5) == 0) begin
            saved = req_v;
            req_v = '0;
            case ($urandom_range(0, 2))
               0:       preset(0);
               1:       preset(M - 1);
               default: preset(int'($urandom_range(0, M - 1)));
            endcase
            req_v = saved;
         end
         for (int k = 0; k < NREQ; k++) begin
            if (!req_v[k] && $urandom_range(0, 1) == 1) begin
               req_v[k] = 1'b1;
               rand_lane(k);
            end
         end
         step(1'($urandom_range(0, 1)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
